// File: rtl/cpu_pkg.sv
// Shared constants, state/class enums and the opcode
// class decoder for the datapath control sequencer.
package cpu_pkg;

  localparam int NUM_REGS = 16;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_BIN, C_UN, C_MD, C_HALT, C_ILL
  } op_class_e;

  function automatic op_class_e op_class(
    input logic [4:0] op
  );
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL:
        op_class = C_BIN;
      OP_NEG, OP_NOT:
        op_class = C_UN;
      OP_MUL, OP_DIV:
        op_class = C_MD;
      OP_HALT:
        op_class = C_HALT;
      default:
        op_class = C_ILL;
    endcase
  endfunction

endpackage

// File: rtl/datapath_control_unit_if.sv
// Control-unit <-> datapath bundle: IR, start and
// memory handshake in; all strobes and selects out.
interface datapath_control_unit_if;
  import cpu_pkg::*;

  logic                start;
  logic [31:0]         IR;
  logic                mem_ready;
  logic                PCout;
  logic                MARin;
  logic                IncPC;
  logic                Zin;
  logic                Zlowout;
  logic                Zhighout;
  logic                PCin;
  logic                Read;
  logic                MDRin;
  logic                MDRout;
  logic                IRin;
  logic                Yin;
  logic                HIin;
  logic                LOin;
  logic [NUM_REGS-1:0] Rin;
  logic [NUM_REGS-1:0] Rout;
  logic [4:0]          opcode;
  logic                run;
  logic                illegal;

  modport master (
    input  start, IR, mem_ready,
    output PCout, MARin, IncPC, Zin,
    output Zlowout, Zhighout, PCin, Read,
    output MDRin, MDRout, IRin, Yin,
    output HIin, LOin, Rin, Rout,
    output opcode, run, illegal
  );

  modport slave (
    output start, IR, mem_ready,
    input  PCout, MARin, IncPC, Zin,
    input  Zlowout, Zhighout, PCin, Read,
    input  MDRin, MDRout, IRin, Yin,
    input  HIin, LOin, Rin, Rout,
    input  opcode, run, illegal
  );
endinterface

// File: rtl/reg_select_decoder.sv
// 4-to-16 one-hot register select with enable.
// en=0 gives all zeros; sel picks the hot bit.
module reg_select_decoder
  import cpu_pkg::*;
(
  input  logic                en,
  input  logic [3:0]          sel,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/datapath_control_unit.sv
// Hardwired fetch/execute sequencer: Clock, clear (async
// low), bus = control bundle (master side).
module datapath_control_unit
  import cpu_pkg::*;
(
  input  logic Clock,
  input  logic clear,
  datapath_control_unit_if.master bus
);

  state_e      state;
  op_class_e   cls;
  logic [1:0]  rst_sync;
  logic        rst_ok;
  logic [4:0]  op;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic [4:0]  opcode_q;
  logic        run_q;
  logic        alu_op;
  logic        rin_en;
  logic        rout_en;
  logic [3:0]  rout_sel;
  logic        unused_ir;

  assign op  = bus.IR[OP_HI:OP_LO];
  assign ra  = bus.IR[RA_HI:RA_LO];
  assign rb  = bus.IR[RB_HI:RB_LO];
  assign rc  = bus.IR[RC_HI:RC_LO];
  assign cls = op_class(op);
  assign unused_ir = ^bus.IR[RC_LO-1:0];

  assign alu_op = (cls == C_BIN) || (cls == C_UN);

  // Reset asserts at once but releases after two edges.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_ok = rst_sync[1];

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state    <= S_IDLE;
      run_q    <= 1'b0;
      opcode_q <= '0;
    end else begin
      unique case (state)
        S_IDLE:
          if (rst_ok && bus.start) begin
            state <= S_T0;
            run_q <= 1'b1;
          end
        S_T0: state <= S_T1;
        S_T1: if (bus.mem_ready) state <= S_T2;
        S_T2: state <= S_T3;
        S_T3:
          case (cls)
            C_HALT: begin
              state <= S_HALT;
              run_q <= 1'b0;
            end
            C_ILL: state <= S_T0;
            default: begin
              state    <= S_T4;
              opcode_q <= op;
            end
          endcase
        S_T4: state <= S_T5;
        S_T5:
          state <= (cls == C_MD) ? S_T6 : S_T0;
        S_T6: state <= S_T0;
        S_HALT: state <= S_HALT;
      endcase
    end
  end

  // Strobes decode from state and IR only; IR is
  // loaded on the edge that enters T3, so it cannot
  // be pre-registered from the T2 view.
  always_comb begin
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Zin      = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.PCin     = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.illegal  = 1'b0;
    rin_en       = 1'b0;
    rout_en      = 1'b0;
    rout_sel     = rb;
    unique case (state)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        bus.illegal = (cls == C_ILL);
        if (alu_op || cls == C_MD) begin
          bus.Yin = 1'b1;
          rout_en = 1'b1;
        end
      end
      S_T4: begin
        bus.Zin = 1'b1;
        rout_en = 1'b1;
        if (cls != C_UN) rout_sel = rc;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        bus.LOin    = (cls == C_MD);
        rin_en      = alu_op;
      end
      S_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      S_IDLE, S_HALT: ;
    endcase
  end

  reg_select_decoder u_rin (
    .en     (rin_en),
    .sel    (ra),
    .onehot (bus.Rin)
  );

  reg_select_decoder u_rout (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (bus.Rout)
  );

  assign bus.opcode = opcode_q;
  assign bus.run    = run_q;

endmodule

// File: tb/tb_datapath_control_unit.sv
// Bench for datapath_control_unit: directed program
// plus random instructions against a cycle-trace model.
module tb_datapath_control_unit;

  localparam logic [13:0] B_PCOUT = 14'h2000;
  localparam logic [13:0] B_MARIN = 14'h1000;
  localparam logic [13:0] B_INCPC = 14'h0800;
  localparam logic [13:0] B_ZIN   = 14'h0400;
  localparam logic [13:0] B_ZLO   = 14'h0200;
  localparam logic [13:0] B_ZHI   = 14'h0100;
  localparam logic [13:0] B_PCIN  = 14'h0080;
  localparam logic [13:0] B_READ  = 14'h0040;
  localparam logic [13:0] B_MDRIN = 14'h0020;
  localparam logic [13:0] B_MDROUT = 14'h0010;
  localparam logic [13:0] B_IRIN  = 14'h0008;
  localparam logic [13:0] B_YIN   = 14'h0004;
  localparam logic [13:0] B_HIIN  = 14'h0002;
  localparam logic [13:0] B_LOIN  = 14'h0001;

  logic Clock = 1'b0;
  logic clear = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [4:0] last_op = 5'd0;

  datapath_control_unit_if bus();

  datapath_control_unit dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  function automatic logic [52:0] mk(
    input logic [13:0] s,
    input logic [15:0] rin,
    input logic [15:0] rout,
    input logic [4:0]  opc,
    input logic        ill,
    input logic        run
  );
    mk = {s, rin, rout, opc, ill, run};
  endfunction

  function automatic logic [52:0] obs();
    obs = {bus.PCout, bus.MARin, bus.IncPC,
           bus.Zin, bus.Zlowout, bus.Zhighout,
           bus.PCin, bus.Read, bus.MDRin,
           bus.MDRout, bus.IRin, bus.Yin,
           bus.HIin, bus.LOin, bus.Rin,
           bus.Rout, bus.opcode, bus.illegal,
           bus.run};
  endfunction

  function automatic bit is_legal(input logic [4:0] op);
    is_legal = op inside {5'd3, 5'd4, 5'd5, 5'd6,
                          5'd7, 5'd8, 5'd9, 5'd10,
                          5'd14, 5'd15, 5'd17,
                          5'd18, 5'd27};
  endfunction

  task automatic chk(input string tag,
                     input logic [52:0] e);
    logic [52:0] o;
    o = obs();
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic restart();
    bus.start = 1'b0;
    clear = 1'b0;
    #1;
    last_op = 5'd0;
    chk("reset", '0);
    @(negedge Clock);
    clear = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      chk("idle", '0);
    end
    bus.start = 1'b1;
  endtask

  task automatic do_instr(input logic [31:0] ir,
                          input int stalls,
                          input bit abort);
    logic [4:0]  op;
    logic [15:0] ra1, rb1, rc1;
    bit bin, un, md, hlt, ill;
    op  = ir[31:27];
    ra1 = 16'h1 << ir[26:23];
    rb1 = 16'h1 << ir[22:19];
    rc1 = 16'h1 << ir[18:15];
    bin = op inside {5'd3, 5'd4, 5'd5, 5'd6,
                     5'd7, 5'd8, 5'd9, 5'd10};
    un  = op inside {5'd17, 5'd18};
    md  = op inside {5'd14, 5'd15};
    hlt = (op == 5'd27);
    ill = !(bin || un || md || hlt);

    @(negedge Clock);
    chk("T0", mk(B_PCOUT | B_MARIN | B_INCPC | B_ZIN,
                 0, 0, last_op, 0, 1));
    bus.IR        = $urandom;
    bus.mem_ready = 1'($urandom);
    bus.start     = 1'($urandom);

    for (int s = 0; s <= stalls; s++) begin
      @(negedge Clock);
      chk("T1", mk(B_ZLO | B_PCIN | B_READ | B_MDRIN,
                   0, 0, last_op, 0, 1));
      bus.mem_ready = (s == stalls);
      bus.start     = 1'($urandom);
    end

    @(negedge Clock);
    chk("T2", mk(B_MDROUT | B_IRIN, 0, 0,
                 last_op, 0, 1));
    bus.IR        = ir;
    bus.mem_ready = 1'($urandom);

    @(negedge Clock);
    if (hlt) begin
      chk("T3_halt", mk(0, 0, 0, last_op, 0, 1));
      repeat (3) begin
        bus.start = 1'b1;
        @(negedge Clock);
        chk("HALT", mk(0, 0, 0, last_op, 0, 0));
        bus.start = 1'($urandom);
      end
      return;
    end
    if (ill) begin
      chk("T3_ill", mk(0, 0, 0, last_op, 1, 1));
      return;
    end
    chk("T3", mk(B_YIN, 0, rb1, last_op, 0, 1));
    bus.mem_ready = 1'($urandom);

    @(negedge Clock);
    last_op = op;
    chk("T4", mk(B_ZIN, 0, un ? rb1 : rc1,
                 op, 0, 1));
    if (abort) begin
      clear = 1'b0;
      #1;
      last_op = 5'd0;
      chk("abort", '0);
      return;
    end

    @(negedge Clock);
    chk("T5", mk(B_ZLO | (md ? B_LOIN : 14'h0),
                 md ? 16'h0 : ra1, 0, op, 0, 1));
    if (md) begin
      @(negedge Clock);
      chk("T6", mk(B_ZHI | B_HIIN, 0, 0, op, 0, 1));
    end
  endtask

  initial begin
    logic [4:0]  op;
    logic [4:0]  legal [12];
    logic [31:0] ir;
    legal = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
              5'd9, 5'd10, 5'd14, 5'd15, 5'd17,
              5'd18};
    bus.start     = 1'b0;
    bus.IR        = '0;
    bus.mem_ready = 1'b1;
    #2;
    restart();
    do_instr(32'h18918000, 0, 0);
    do_instr(32'h90900000, 0, 0);
    do_instr(32'h70118000, 0, 0);
    do_instr(32'h18918000, 3, 0);
    do_instr({5'b11111, 27'h1234567}, 0, 0);
    do_instr(32'h18918000, 0, 1);
    restart();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 5'($urandom);
        while (is_legal(op));
      end else begin
        op = legal[$urandom_range(0, 11)];
      end
      ir = {op, 27'($urandom)};
      do_instr(ir, $urandom_range(0, 3), 0);
    end
    do_instr(32'hD8000000, 0, 0);
    restart();
    do_instr(32'h20918000, 1, 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
